// File: rtl/acc_cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit accumulator datapath.
// Owns pc and ir; every strobe and mem_addr is decoded combinationally from state and registers.
module acc_cpu_sequencer #(
    parameter logic [7:0] RESET_PC        = 8'h00,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] acc_value,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic       acc_load,
    output logic       acc_increment,
    output logic [3:0] alu_op,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       instr_done,
    output logic       halted
);
    // state   | meaning
    // FETCH   | pc on mem_addr; advance only when run is high
    // DECODE  | opcode byte on mem_rdata; 1-byte instructions finish here
    // OPERAND | operand byte on mem_rdata; jumps and STA finish here
    // EXEC    | memory operand on mem_rdata; accumulator loads
    // HALT    | stopped until reset
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [3:0] ALU_PASS_B = 4'd5;

    state_t     state, state_next;
    logic [7:0] pc_next, ir_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        ir_next       = ir;
        mem_addr      = pc;
        mem_we        = 1'b0;
        acc_load      = 1'b0;
        acc_increment = 1'b0;
        alu_op        = 4'd0;
        instr_done    = 1'b0;
        halted        = 1'b0;

        // Reset masks every strobe so an aborted instruction cannot write or load.
        if (reset) begin
            mem_addr = RESET_PC;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        pc_next    = pc + 8'd1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ir_next = mem_rdata;
                    case (mem_rdata[7:4])
                        OP_NOP: begin
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        OP_INC: begin
                            acc_increment = 1'b1;
                            instr_done    = 1'b1;
                            state_next    = S_FETCH;
                        end
                        OP_HLT: begin
                            instr_done = 1'b1;
                            state_next = S_HALT;
                        end
                        4'hC, 4'hD, 4'hE: begin
                            instr_done = 1'b1;
                            state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                        end
                        default: begin
                            pc_next    = pc + 8'd1;
                            state_next = S_OPERAND;
                        end
                    endcase
                end
                S_OPERAND: begin
                    case (ir[7:4])
                        OP_JMP, OP_JZ, OP_JNZ: begin
                            if ((ir[7:4] == OP_JMP) ||
                                (ir[7:4] == OP_JZ  && acc_value == 8'h00) ||
                                (ir[7:4] == OP_JNZ && acc_value != 8'h00))
                                pc_next = mem_rdata;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        OP_STA: begin
                            mem_addr   = mem_rdata;
                            mem_we     = 1'b1;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        default: begin
                            mem_addr   = mem_rdata;
                            state_next = S_EXEC;
                        end
                    endcase
                end
                S_EXEC: begin
                    acc_load = 1'b1;
                    // ADD..XOR opcodes 3..7 map onto ALU ops 0..4.
                    alu_op     = (ir[7:4] == OP_LDA) ? ALU_PASS_B : (ir[7:4] - 4'd3);
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Bench for acc_cpu_sequencer: two instances (default and RESET_PC=FE/HALT_ON_ILLEGAL=1),
// each with its own memory, ALU and accumulator glue, checked against an instruction-level model.
module tb_acc_cpu_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, run;
    int checks = 0;
    int failures = 0;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rdata_a, rdata_b, acc_a, acc_b;
    logic [7:0] a_addr, a_pc, a_ir, b_addr, b_pc, b_ir;
    logic       a_we, a_load, a_inc, a_done, a_halted;
    logic       b_we, b_load, b_inc, b_done, b_halted;
    logic [3:0] a_op, b_op;

    acc_cpu_sequencer dut_a (
        .clk(clk), .reset(reset), .run(run), .mem_rdata(rdata_a), .acc_value(acc_a),
        .mem_addr(a_addr), .mem_we(a_we), .acc_load(a_load), .acc_increment(a_inc),
        .alu_op(a_op), .pc(a_pc), .ir(a_ir), .instr_done(a_done), .halted(a_halted)
    );

    acc_cpu_sequencer #(.RESET_PC(8'hFE), .HALT_ON_ILLEGAL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .run(run), .mem_rdata(rdata_b), .acc_value(acc_b),
        .mem_addr(b_addr), .mem_we(b_we), .acc_load(b_load), .acc_increment(b_inc),
        .alu_op(b_op), .pc(b_pc), .ir(b_ir), .instr_done(b_done), .halted(b_halted)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return y;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= acc_a;
        rdata_a <= mem_a[a_addr];
        if (a_load) acc_a <= alu_f(a_op, acc_a, rdata_a);
        else if (a_inc) acc_a <= acc_a + 8'd1;
    end

    always @(posedge clk) begin
        if (b_we) mem_b[b_addr] <= acc_b;
        rdata_b <= mem_b[b_addr];
        if (b_load) acc_b <= alu_f(b_op, acc_b, rdata_b);
        else if (b_inc) acc_b <= acc_b + 8'd1;
    end

    // Instruction-level reference model.
    logic [7:0] m_mem [256];
    logic [7:0] m_acc, m_pc;
    bit         m_halt;

    task automatic model_step(output int lat, output logic [7:0] opb);
        logic [7:0] pc1, a;
        opb = m_mem[m_pc];
        pc1 = m_pc + 8'd1;
        a   = m_mem[pc1];
        lat = 4;
        case (opb[7:4])
            4'h0, 4'hC, 4'hD, 4'hE: begin m_pc = pc1; lat = 2; end
            4'h8: begin m_acc = m_acc + 8'd1; m_pc = pc1; lat = 2; end
            4'hF: begin m_halt = 1'b1; m_pc = pc1; lat = 2; end
            4'h9: begin m_pc = a; lat = 3; end
            4'hA: begin m_pc = (m_acc == 8'h00) ? a : pc1 + 8'd1; lat = 3; end
            4'hB: begin m_pc = (m_acc != 8'h00) ? a : pc1 + 8'd1; lat = 3; end
            4'h2: begin m_mem[a] = m_acc; m_pc = pc1 + 8'd1; lat = 3; end
            4'h1: begin m_acc = m_mem[a]; m_pc = pc1 + 8'd1; end
            4'h3: begin m_acc = m_acc + m_mem[a]; m_pc = pc1 + 8'd1; end
            4'h4: begin m_acc = m_acc - m_mem[a]; m_pc = pc1 + 8'd1; end
            4'h5: begin m_acc = m_acc & m_mem[a]; m_pc = pc1 + 8'd1; end
            4'h6: begin m_acc = m_acc | m_mem[a]; m_pc = pc1 + 8'd1; end
            default: begin m_acc = m_acc ^ m_mem[a]; m_pc = pc1 + 8'd1; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] <= 8'h00;
            mem_b[i] <= 8'h00;
        end
        acc_a <= 8'h00;
        acc_b <= 8'h00;
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        run = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_pc, a_ir, a_addr} !== 24'h000000) begin
            failures++;
            $display("FAIL reset_regs_a got pc=%0h ir=%0h addr=%0h exp 0/0/0", a_pc, a_ir, a_addr);
        end
        checks++;
        if ({a_we, a_load, a_inc, a_done, a_halted, a_op} !== 9'd0) begin
            failures++;
            $display("FAIL reset_strobes_a got %b exp all zero", {a_we, a_load, a_inc, a_done, a_halted, a_op});
        end
        checks++;
        if ({b_pc, b_addr, b_ir} !== 24'hFEFE00) begin
            failures++;
            $display("FAIL reset_regs_b got pc=%0h addr=%0h ir=%0h exp fe/fe/0", b_pc, b_addr, b_ir);
        end
        tick();
    endtask

    task automatic test_program();
        int ndone, last_done, halt_cyc;
        apply_reset();
        mem_a[0] <= 8'h10; mem_a[1] <= 8'h20; mem_a[2] <= 8'h30; mem_a[3] <= 8'h21;
        mem_a[4] <= 8'h20; mem_a[5] <= 8'h22; mem_a[6] <= 8'hF0;
        mem_a[8'h20] <= 8'h05; mem_a[8'h21] <= 8'h07;
        #1;
        reset = 1'b0;
        run   = 1'b1;
        ndone = 0; last_done = 0; halt_cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (a_done) begin ndone++; last_done = c; end
            if (a_halted && halt_cyc == 0) halt_cyc = c;
            tick();
        end
        checks++;
        if (ndone != 4) begin failures++; $display("FAIL prog_done_count got %0d exp 4", ndone); end
        checks++;
        if (last_done != 13 || halt_cyc != 14) begin
            failures++;
            $display("FAIL prog_latency got last_done=%0d halt=%0d exp 13/14", last_done, halt_cyc);
        end
        checks++;
        if (mem_a[8'h22] !== 8'h0C || acc_a !== 8'h0C) begin
            failures++;
            $display("FAIL prog_result got mem22=%0h acc=%0h exp 0c/0c", mem_a[8'h22], acc_a);
        end
        checks++;
        if (a_pc !== 8'h07) begin failures++; $display("FAIL prog_pc got %0h exp 07", a_pc); end
    endtask

    task automatic test_jump(input logic [7:0] acc0, input logic [7:0] exp_pc);
        int done_c;
        apply_reset();
        mem_a[0] <= 8'hA0; mem_a[1] <= 8'h10; acc_a <= acc0;
        #1;
        reset = 1'b0;
        run   = 1'b1;
        done_c = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (a_done && done_c == 0) done_c = c;
            tick();
        end
        checks++;
        if (done_c != 3 || a_pc !== exp_pc) begin
            failures++;
            $display("FAIL jz_acc%0h got done_cycle=%0d pc=%0h exp 3/%0h", acc0, done_c, a_pc, exp_pc);
        end
    endtask

    task automatic test_run_stall();
        apply_reset();
        mem_a[0] <= 8'h80;
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (a_pc !== 8'h00 || a_addr !== 8'h00 || {a_we, a_load, a_inc, a_done} !== 4'd0) begin
                failures++;
                $display("FAIL stall_hold got pc=%0h addr=%0h strobes=%b exp 0/0/0", a_pc, a_addr, {a_we, a_load, a_inc, a_done});
            end
            tick();
        end
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (a_addr !== 8'h00) begin failures++; $display("FAIL stall_first_fetch got addr=%0h exp 00", a_addr); end
        tick();
        @(negedge clk);
        checks++;
        if (!(a_inc === 1'b1 && a_done === 1'b1 && a_pc === 8'h01)) begin
            failures++;
            $display("FAIL stall_inc got inc=%b done=%b pc=%0h exp 1/1/01", a_inc, a_done, a_pc);
        end
        tick();
        checks++;
        if (acc_a !== 8'h01) begin failures++; $display("FAIL stall_acc got %0h exp 01", acc_a); end
    endtask

    task automatic test_reset_mid_sta();
        apply_reset();
        mem_a[0] <= 8'h20; mem_a[1] <= 8'h40; mem_a[8'h40] <= 8'h5A; acc_a <= 8'h33;
        #1;
        reset = 1'b0;
        run   = 1'b1;
        repeat (2) begin @(negedge clk); tick(); end
        @(negedge clk);
        checks++;
        if (a_we !== 1'b1 || a_addr !== 8'h40) begin
            failures++;
            $display("FAIL sta_operand got we=%b addr=%0h exp 1/40", a_we, a_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (a_we !== 1'b0 || a_addr !== 8'h00) begin
            failures++;
            $display("FAIL sta_abort got we=%b addr=%0h exp 0/00", a_we, a_addr);
        end
        tick();
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        checks++;
        if (a_pc !== 8'h00 || a_addr !== 8'h00 || mem_a[8'h40] !== 8'h5A || a_done !== 1'b0) begin
            failures++;
            $display("FAIL sta_after_reset got pc=%0h addr=%0h mem40=%0h done=%b exp 00/00/5a/0", a_pc, a_addr, mem_a[8'h40], a_done);
        end
        tick();
    endtask

    task automatic test_wrap_illegal();
        apply_reset();
        mem_b[8'hFE] <= 8'h10; mem_b[8'hFF] <= 8'h30; mem_b[8'h30] <= 8'hAA; mem_b[0] <= 8'hC0;
        #1;
        reset = 1'b0;
        run   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (b_addr !== 8'hFF) begin failures++; $display("FAIL wrap_operand_addr got %0h exp ff", b_addr); end
            end
            if (c == 3) begin
                checks++;
                if (b_pc !== 8'h00 || b_addr !== 8'h30) begin
                    failures++;
                    $display("FAIL wrap_pc got pc=%0h addr=%0h exp 00/30", b_pc, b_addr);
                end
            end
            if (c == 4) begin
                checks++;
                if (b_load !== 1'b1 || b_op !== 4'd5 || b_done !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_exec got load=%b op=%0d done=%b exp 1/5/1", b_load, b_op, b_done);
                end
            end
            if (c == 7) begin
                checks++;
                if (b_halted !== 1'b1) begin failures++; $display("FAIL illegal_halt got %b exp 1", b_halted); end
            end
            tick();
        end
        checks++;
        if (acc_b !== 8'hAA) begin failures++; $display("FAIL wrap_acc got %0h exp aa", acc_b); end
        for (int c = 0; c < 6; c++) begin
            run = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (b_halted !== 1'b1 || b_pc !== 8'h01 || b_addr !== 8'h01 ||
                {b_we, b_load, b_inc, b_done, b_op} !== 8'd0) begin
                failures++;
                $display("FAIL halt_hold got halted=%b pc=%0h addr=%0h exp 1/01/01 no strobes", b_halted, b_pc, b_addr);
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (b_halted !== 1'b0 || b_addr !== 8'hFE) begin
            failures++;
            $display("FAIL halt_reset got halted=%b addr=%0h exp 0/fe", b_halted, b_addr);
        end
        tick();
    endtask

    task automatic test_random();
        int explat, lat, mem_bad;
        logic [7:0] opb, pc_before;
        bit fetching, got, stop;
        for (int p = 0; p < 12; p++) begin
            apply_reset();
            for (int i = 0; i < 256; i++) begin
                m_mem[i] = 8'($urandom);
                mem_a[i] <= m_mem[i];
            end
            m_acc = 8'($urandom);
            acc_a <= m_acc;
            m_pc = 8'h00;
            m_halt = 1'b0;
            #1;
            reset = 1'b0;
            run = ($urandom_range(0, 3) != 0);
            stop = 1'b0;
            for (int n = 0; n < 40 && !stop; n++) begin
                pc_before = m_pc;
                model_step(explat, opb);
                fetching = 1'b1;
                lat = 0;
                got = 1'b0;
                for (int c = 0; c < 80 && !got; c++) begin
                    @(negedge clk);
                    if (fetching) begin
                        checks++;
                        if (a_addr !== pc_before || {a_we, a_load, a_inc, a_done} !== 4'd0) begin
                            failures++;
                            $display("FAIL rnd_fetch got addr=%0h strobes=%b exp %0h/0000", a_addr, {a_we, a_load, a_inc, a_done}, pc_before);
                        end
                        if (run) begin fetching = 1'b0; lat = 1; end
                    end else begin
                        lat++;
                        if (a_done) got = 1'b1;
                    end
                    tick();
                    run = ($urandom_range(0, 3) != 0);
                end
                checks++;
                if (!got) begin
                    failures++;
                    $display("FAIL rnd_timeout got no instr_done exp one for op %0h at pc %0h", opb, pc_before);
                    stop = 1'b1;
                end else begin
                    if (lat != explat) begin
                        failures++;
                        $display("FAIL rnd_latency got %0d exp %0d op=%0h", lat, explat, opb);
                    end
                    checks++;
                    if (a_pc !== m_pc || acc_a !== m_acc || a_ir !== opb) begin
                        failures++;
                        $display("FAIL rnd_state got pc=%0h acc=%0h ir=%0h exp %0h/%0h/%0h", a_pc, acc_a, a_ir, m_pc, m_acc, opb);
                    end
                    if (m_halt) begin
                        @(negedge clk);
                        checks++;
                        if (a_halted !== 1'b1) begin failures++; $display("FAIL rnd_halt got %b exp 1", a_halted); end
                        tick();
                        stop = 1'b1;
                    end
                end
            end
            mem_bad = 0;
            for (int i = 0; i < 256; i++) if (mem_a[i] !== m_mem[i]) mem_bad++;
            checks++;
            if (mem_bad != 0) begin failures++; $display("FAIL rnd_memory got %0d differing bytes exp 0", mem_bad); end
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        test_reset();
        test_program();
        test_jump(8'h00, 8'h10);
        test_jump(8'h03, 8'h02);
        test_run_stall();
        test_reset_mid_sta();
        test_wrap_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_cpu_sequencer.md
Name: acc_cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit accumulator datapath: accumulator register, ALU, 256x8 memory.
- Fetches 1- or 2-byte instructions from memory, decodes them, and drives memory address/write, ALU op select and accumulator load/increment strobes.
- Owns the PC and the instruction register.
- Top-level glue, outside this block, wires ALU a = acc_value, ALU b = mem_rdata, accumulator data_in = ALU result, memory data_in = acc_value.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ON_ILLEGAL, 0, 1 = undefined opcodes enter HALT; 0 = undefined opcodes execute as NOP.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- run  input  1  when low, FSM holds in FETCH (instruction-boundary stall)
- mem_rdata  input  8  memory read data, valid the cycle after mem_addr is presented
- acc_value  input  8  current accumulator output
- mem_addr  output  8  memory address
- mem_we  output  1  memory write strobe
- acc_load  output  1  accumulator load strobe
- acc_increment  output  1  accumulator increment strobe
- alu_op  output  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
- pc  output  8  program counter (registered)
- ir  output  8  instruction register (registered)
- instr_done  output  1  one-cycle pulse on an instruction's final cycle
- halted  output  1  high in HALT

Behaviour:
- Opcode = opcode byte [7:4]; [3:0] ignored. 2-byte instructions: opcode byte, then operand byte.
  - 0 NOP, 1 LDA a, 2 STA a, 3 ADD a, 4 SUB a, 5 AND a, 6 OR a, 7 XOR a, 8 INC, 9 JMP a, A JZ a, B JNZ a, F HLT.
  - C/D/E: per HALT_ON_ILLEGAL.
- Reset (sync, priority over everything): state=FETCH, pc=RESET_PC, ir=0.
  - While reset is high, mem_we, acc_load, acc_increment, instr_done and halted are 0, alu_op=0, mem_addr=RESET_PC.
  - Reset mid-instruction aborts it; no write or load occurs in the reset cycle.
- Strobes and mem_addr are combinational from state/registers. alu_op=0 outside EXEC. mem_we/acc_load/acc_increment are 0 unless stated below.
- FETCH:
  - mem_addr=pc.
  - If run: pc<=pc+1, go to DECODE.
  - Else hold; pc unchanged.
- DECODE: ir<=mem_rdata; decode mem_rdata[7:4].
  - NOP: instr_done=1, go to FETCH.
  - INC: acc_increment=1, instr_done=1, go to FETCH.
  - HLT: instr_done=1, go to HALT.
  - 2-byte op: mem_addr=pc, pc<=pc+1, go to OPERAND.
- OPERAND: mem_rdata = operand (address).
  - JMP: pc<=operand.
  - JZ: pc<=operand iff acc_value==0.
  - JNZ: pc<=operand iff acc_value!=0.
  - STA: mem_addr=operand, mem_we=1.
  - All of the above: instr_done=1, go to FETCH.
  - LDA/ALU ops: mem_addr=operand, go to EXEC.
- EXEC: mem_rdata = memory operand.
  - acc_load=1; alu_op=5 for LDA, else 0..4 for ADD..XOR.
  - instr_done=1, go to FETCH.
- HALT: halted=1, all strobes 0, mem_addr=pc; stays until reset. run has no effect.
- Latency, from FETCH with run high to the instr_done cycle inclusive:
  - NOP/INC/HLT: 2 cycles.
  - STA/JMP/JZ/JNZ: 3 cycles.
  - LDA/ALU: 4 cycles.
- PC arithmetic is mod 256: 8'hFF+1 wraps to 8'h00, including an operand fetch that straddles the wrap.
- run is sampled only in FETCH; dropping run mid-instruction does not stall that instruction.
- Jump taken to its own address is legal (tight loop).

Test Plan:
- Program mem[0..6] = 10 20 30 21 20 22 F0, mem[20]=05, mem[21]=07; reset, run=1 -> mem[22]=0C, halted after 13 cycles, exactly 4 instr_done pulses, pc=07.
- acc=0, program A0 10 (JZ 10) -> pc=10 after 3 cycles. Repeat with acc=3 -> pc=02, no jump.
- run=0 after reset for 5 cycles -> pc stays 00, no strobes. Raise run -> first fetch proceeds, mem_addr=00.
- RESET_PC=FE, mem[FE]=10, mem[FF]=30, mem[30]=AA -> operand fetched from FF, pc wraps to 00, acc loaded with AA via alu_op=5.
- Assert reset during OPERAND of an STA -> mem_we=0 that cycle; next cycle state FETCH, pc=RESET_PC.
- Opcode C0 with HALT_ON_ILLEGAL=0 -> 2-cycle NOP. With HALT_ON_ILLEGAL=1 -> halted=1, held until reset.
